// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared seven-segment constants: active-low GFEDCBA glyphs for
//            hex digits 0..F plus the all-dark pattern.
// Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_DARK = 7'h7F;

    // Packed array; element 0 is the rightmost entry of the list.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic seg7_t glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Purpose  : Combinational hex nibble to active-low GFEDCBA segment lookup.
// Revision : 1.0  initial release
// ============================================================================
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] segs_o
);

    assign segs_o = glyph(nibble_i);

endmodule
`default_nettype wire

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Purpose  : Time-multiplexed driver for NUM_DIGITS common-anode hex digits
//            with shadowed digit/blank data and registered outputs.
// Revision : 1.0  initial release
// ============================================================================
module seven_seg_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                enable,
    input  logic                                                load,
    input  logic [4*NUM_DIGITS-1:0]                             digits,
    input  logic [NUM_DIGITS-1:0]                               blank_mask,
    output logic [NUM_DIGITS-1:0]                               anode,
    output logic [6:0]                                          segs,
    output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [6:0]              segs_q, segs_d;

    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_anode_lit;
    logic [6:0]              w_glyph;

    // Constant-index mux keeps non-power-of-two digit counts in range.
    always_comb begin
        w_nibble    = 4'h0;
        w_blank     = 1'b0;
        w_anode_lit = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                w_nibble       = shadow_dig_q[4*i +: 4];
                w_blank        = shadow_blank_q[i];
                w_anode_lit[i] = 1'b0;
            end
        end
    end

    hex_to_seg7 u_glyph (
        .nibble_i (w_nibble),
        .segs_o   (w_glyph)
    );

    always_comb begin
        presc_d        = presc_q;
        idx_d          = idx_q;
        shadow_dig_d   = shadow_dig_q;
        shadow_blank_d = shadow_blank_q;
        anode_d        = '1;
        segs_d         = SEG_DARK;

        if (enable && !w_blank) begin
            anode_d = w_anode_lit;
            segs_d  = w_glyph;
        end

        if (load) begin
            shadow_dig_d   = digits;
            shadow_blank_d = blank_mask;
        end

        if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q        <= '0;
            idx_q          <= '0;
            shadow_dig_q   <= '0;
            shadow_blank_q <= '0;
            anode_q        <= '1;
            segs_q         <= SEG_DARK;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            shadow_dig_q   <= shadow_dig_d;
            shadow_blank_q <= shadow_blank_d;
            anode_q        <= anode_d;
            segs_q         <= segs_d;
        end
    end

    assign anode     = anode_q;
    assign segs      = segs_q;
    assign digit_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Purpose  : Self-checking bench for seven_seg_scanner (4 digits, divide-by-4).
// Revision : 1.0  initial release
// ============================================================================
module tb_seven_seg_scanner;

    localparam int N  = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic [1:0]  digit_idx;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } vec_t;
    vec_t tab [16];

    // Reference state: counts and per-digit arrays, outputs lag by one edge.
    int         m_presc;
    int         m_idx;
    int         m_dig [N];
    logic [3:0] m_blank;
    logic [3:0] m_anode;
    logic [6:0] m_segs;

    seven_seg_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .digits     (digits),
        .blank_mask (blank_mask),
        .anode      (anode),
        .segs       (segs),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) begin
            m_presc = 0;
            m_idx   = 0;
            for (int i = 0; i < N; i++) m_dig[i] = 0;
            m_blank = 4'h0;
            m_anode = 4'hF;
            m_segs  = 7'h7F;
        end else begin
            if (!enable || m_blank[m_idx]) begin
                m_anode = 4'hF;
                m_segs  = 7'h7F;
            end else begin
                m_anode = 4'hF;
                m_anode[m_idx] = 1'b0;
                m_segs  = tab[m_dig[m_idx]].seg;
            end
            if (load) begin
                for (int i = 0; i < N; i++) m_dig[i] = int'(digits[4*i +: 4]);
                m_blank = blank_mask;
            end
            if (enable) begin
                m_presc = m_presc + 1;
                if (m_presc == RD) begin
                    m_presc = 0;
                    m_idx   = (m_idx + 1) % N;
                end
            end
        end
        #1;
        chk("anode", int'(anode), int'(m_anode));
        chk("segs", int'(segs), int'(m_segs));
        chk("digit_idx", int'(digit_idx), m_idx);
        chk("anode_one_low", int'($countones(~anode) <= 1), 1);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        tab[0]  = '{4'h0, 7'h40}; tab[1]  = '{4'h1, 7'h79};
        tab[2]  = '{4'h2, 7'h24}; tab[3]  = '{4'h3, 7'h30};
        tab[4]  = '{4'h4, 7'h19}; tab[5]  = '{4'h5, 7'h12};
        tab[6]  = '{4'h6, 7'h02}; tab[7]  = '{4'h7, 7'h78};
        tab[8]  = '{4'h8, 7'h00}; tab[9]  = '{4'h9, 7'h10};
        tab[10] = '{4'hA, 7'h08}; tab[11] = '{4'hB, 7'h03};
        tab[12] = '{4'hC, 7'h46}; tab[13] = '{4'hD, 7'h21};
        tab[14] = '{4'hE, 7'h06}; tab[15] = '{4'hF, 7'h0E};

        // Reset state
        steps(2);
        chk("reset_anode", int'(anode), 'hF);
        chk("reset_segs", int'(segs), 'h7F);

        // Basic scan of 3210
        @(negedge clk);
        reset = 1'b0; enable = 1'b1; load = 1'b1; digits = 16'h3210; blank_mask = 4'h0;
        step();
        load = 1'b0;
        steps(20);

        // Mid-period load of FEDC
        steps(1);
        load = 1'b1; digits = 16'hFEDC;
        step();
        load = 1'b0;
        steps(20);

        // Glyph table, every nibble on every digit
        for (int i = 0; i < 16; i++) begin
            load = 1'b1; digits = {4{tab[i].nib}}; blank_mask = 4'h0;
            step();
            load = 1'b0;
            step();
            chk("glyph_table", int'(segs), int'(tab[i].seg));
        end

        // Blanking digits 1 and 3
        load = 1'b1; digits = 16'h7654; blank_mask = 4'b1010;
        step();
        load = 1'b0;
        steps(24);

        // Enable low for 10 cycles mid-slot
        load = 1'b1; blank_mask = 4'h0;
        step();
        load = 1'b0;
        steps(2);
        enable = 1'b0;
        steps(10);
        chk("disabled_anode", int'(anode), 'hF);
        chk("disabled_segs", int'(segs), 'h7F);
        enable = 1'b1;
        steps(12);

        // Reset during digit 2
        for (int k = 0; k < 40 && m_idx != 2; k++) step();
        chk("wait_digit2", m_idx, 2);
        reset = 1'b1;
        step();
        chk("midreset_idx", int'(digit_idx), 0);
        reset = 1'b0;
        step();
        chk("midreset_segs", int'(segs), 'h40);
        chk("midreset_anode", int'(anode), 'hE);
        steps(10);

        // Load coincident with wrap from digit 3 to 0
        load = 1'b1; digits = 16'h1111; blank_mask = 4'h0;
        step();
        load = 1'b0;
        for (int k = 0; k < 40 && !(m_idx == 3 && m_presc == RD - 1); k++) step();
        chk("wait_wrap", int'(m_idx == 3 && m_presc == RD - 1), 1);
        load = 1'b1; digits = 16'h5678;
        step();
        load = 1'b0;
        step();
        chk("wrap_load_anode", int'(anode), 'hE);
        chk("wrap_load_segs", int'(segs), 'h00);
        steps(8);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            reset      = ($urandom_range(0, 99) == 0);
            enable     = ($urandom_range(0, 9) != 0);
            load       = ($urandom_range(0, 7) == 0);
            digits     = 16'($urandom);
            blank_mask = 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
